// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle fetch sequencer for the MIPS fetch path.
// Owns the program counter and the instruction latch, issues read requests
// to instruction memory, and presents one instruction at a time to decode.
//
// Handshake semantics:
//   - imemReq_FC is high for every cycle spent in FETCH. A read completes
//     on the first rising edge where imemReq_FC=1 and imemAck_FC=1, and
//     imemData_FC is captured on that edge. imemAck_FC is ignored when no
//     request is outstanding.
//   - instrValid_FC is high for every cycle spent in ISSUE. Decode accepts
//     the instruction on the first rising edge where instrValid_FC=1 and
//     stall_FC=0. Until then instr_FC and pc_FC are held stable.
module fetch_ctrl #(
   parameter logic [7:0] PC_STEP = 8'd4,
   parameter int         TIMEOUT = 16,
   parameter logic [5:0] HALT_OP = 6'h3F
) (
   input  logic        clk_FC,
   input  logic        rst_FC,
   input  logic        start_FC,
   input  logic [7:0]  initialPC_FC,
   input  logic        stall_FC,
   input  logic        branchTaken_FC,
   input  logic [7:0]  branchTarget_FC,
   output logic        imemReq_FC,
   output logic [7:0]  imemAddr_FC,
   input  logic        imemAck_FC,
   input  logic [31:0] imemData_FC,
   output logic [7:0]  pc_FC,
   output logic [31:0] instr_FC,
   output logic        instrValid_FC,
   output logic        halted_FC,
   output logic        timeoutErr_FC,
   output logic [15:0] fetchCount_FC,
   output logic [1:0]  dbgState_FC
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   // Timer value seen on the last FETCH cycle allowed before giving up.
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  timer_q, timer_d;
   logic        terr_q, terr_d;

   // State register; reset wins over every other input in every state.
   always_ff @(posedge clk_FC) begin
      if (rst_FC) begin
         state_q <= S_IDLE;
         pc_q    <= 8'd0;
         instr_q <= 32'd0;
         count_q <= 16'd0;
         timer_q <= 8'd0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         count_q <= count_d;
         timer_q <= timer_d;
         terr_q  <= terr_d;
      end
   end

   // Next-state logic: start, memory wait/timeout, issue/redirect, halt.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      count_d = count_q;
      timer_d = timer_q;
      terr_d  = terr_q;
      case (state_q)
         S_IDLE: begin
            if (start_FC) begin
               pc_d    = initialPC_FC;
               timer_d = 8'd0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            // An ack on the final allowed cycle still counts as a success.
            if (imemAck_FC) begin
               instr_d = imemData_FC;
               timer_d = 8'd0;
               state_d = S_ISSUE;
            end else begin
               timer_d = timer_q + 8'd1;
               if (timer_q == TIMER_LAST) begin
                  terr_d  = 1'b1;
                  state_d = S_HALT;
               end
            end
         end
         S_ISSUE: begin
            if (!stall_FC) begin
               count_d = count_q + 16'd1;
               if (instr_q[31:26] == HALT_OP) begin
                  // The halt word is counted but the PC stays on it.
                  state_d = S_HALT;
               end else begin
                  pc_d    = branchTaken_FC ? branchTarget_FC : (pc_q + PC_STEP);
                  state_d = S_FETCH;
               end
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign imemReq_FC    = (state_q == S_FETCH);
   assign imemAddr_FC   = pc_q;
   assign pc_FC         = pc_q;
   assign instr_FC      = instr_q;
   assign instrValid_FC = (state_q == S_ISSUE);
   assign halted_FC     = (state_q == S_HALT);
   assign timeoutErr_FC = terr_q;
   assign fetchCount_FC = count_q;
   assign dbgState_FC   = state_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Multi-cycle fetch sequencer for the MIPS fetch path. Owns the program counter and the instruction latch. Drives a request/acknowledge read port toward instruction memory and presents one fetched instruction at a time to the decode field splitter. Handles start-up from an externally supplied initial PC, decode stalls, branch redirects, a halt opcode and memory-timeout detection.

Parameters:
PC_STEP, 4, increment added to PC after each issued instruction (8-bit, modulo 256)
TIMEOUT, 16, max cycles in FETCH without imemAck_FC before error halt (2..255)
HALT_OP, 6'h3F, opcode field value (instr[31:26]) that stops fetching

Ports:
clk_FC  in  1  clock, all state on rising edge
rst_FC  in  1  reset, synchronous, active-high
start_FC  in  1  begin fetching from initialPC_FC; sampled only in IDLE
initialPC_FC  in  8  start address
stall_FC  in  1  downstream cannot accept instruction; holds ISSUE
branchTaken_FC  in  1  redirect request, sampled only in ISSUE when stall_FC=0
branchTarget_FC  in  8  redirect address
imemReq_FC  out  1  read request to instruction memory
imemAddr_FC  out  8  read address (equals pc_FC while imemReq_FC=1)
imemAck_FC  in  1  memory returns data this cycle
imemData_FC  in  32  instruction word, valid when imemAck_FC=1
pc_FC  out  8  current PC
instr_FC  out  32  latched instruction
instrValid_FC  out  1  instr_FC valid for decode
halted_FC  out  1  controller stopped (halt opcode or timeout)
timeoutErr_FC  out  1  halt was caused by memory timeout
fetchCount_FC  out  16  number of instructions issued (accepted with stall_FC=0)

Behaviour:
- Reset (rst_FC=1 at a clock edge, in any state, including mid-fetch):
  - state=IDLE
  - pc_FC=0, instr_FC=0, fetchCount_FC=0, timer=0
  - instrValid_FC=0, halted_FC=0, timeoutErr_FC=0
  - Reset has priority over all other inputs.
- State encoding: IDLE, FETCH, ISSUE, HALT.
- imemReq_FC=1 only in FETCH (decoded from state). imemAddr_FC=pc_FC always.
- instrValid_FC=1 only in ISSUE. halted_FC=1 only in HALT.
- IDLE:
  - start_FC=1: pc<=initialPC_FC, timer<=0, go FETCH.
  - Otherwise remain in IDLE.
- FETCH:
  - imemAck_FC=1: instr<=imemData_FC, timer<=0, go ISSUE. A same-cycle ack is legal, giving a minimum of 1 cycle in FETCH.
  - No ack: timer<=timer+1. If timer==TIMEOUT-1, go HALT with timeoutErr<=1.
  - An ack arriving on the timeout cycle wins: data is captured, no error.
- ISSUE:
  - stall_FC=1: hold state, pc, instr and instrValid; no count.
  - stall_FC=0:
    - fetchCount<=fetchCount+1 (wraps at 2^16).
    - If instr[31:26]==HALT_OP, go HALT; pc unchanged; the halt word itself is counted.
    - Else pc<=branchTaken_FC ? branchTarget_FC : pc+PC_STEP (8-bit wrap, 0xFC+4=0x00), then go FETCH.
- HALT: terminal. start_FC, stall_FC and branch inputs are ignored; only rst_FC leaves it.
- Latency: start at edge N puts FETCH at N+1. With an immediate ack, ISSUE (instrValid_FC=1) is at N+2. Steady state with zero-wait memory and no stalls is 2 cycles per instruction.
- imemAck_FC outside FETCH is ignored.
- start_FC outside IDLE is ignored.

Test Plan:
- Reset then start_FC=1, initialPC_FC=0x10, zero-wait memory -> imemAddr_FC sequence 0x10,0x14,0x18; instrValid_FC pulses every 2 cycles; fetchCount_FC increments once per issue.
- Ack delayed 3 cycles -> imemReq_FC high for 4 cycles at a constant address; instr_FC equals the acked data; no timeout.
- stall_FC held 5 cycles in ISSUE -> instr_FC and pc_FC frozen, instrValid_FC high throughout, fetchCount_FC unchanged until release.
- branchTaken_FC=1, branchTarget_FC=0x40 in unstalled ISSUE at pc 0x08 -> next imemAddr_FC=0x40. Separately, start at pc=0xFC with no branch -> next fetch address 0x00.
- Memory returns 0xFC000000 (op 0x3F) -> after issue, halted_FC=1, imemReq_FC=0, count includes the halt word; start_FC is then ignored; rst_FC returns to IDLE.
- Never ack with TIMEOUT=16 -> HALT after exactly 16 FETCH cycles with timeoutErr_FC=1. Separately, rst_FC asserted during FETCH -> all outputs at reset values on the next cycle.
